// File: rtl/mips_abb_pkg.sv
// Shared MIPS core types: reset level, register address/word types and the
// register-file write-port request carried through the long-latency queue.
package mips_abb_pkg;

    localparam logic RESET = 1'b0;

    typedef logic [4:0]  reg_addr;
    typedef logic [31:0] reg_word;

    localparam reg_addr REG_ZERO = 5'd0;

    typedef struct packed {
        reg_addr add;
        reg_word data;
    } rf_wreq_t;

    localparam int WPORT_DEPTH  = 4;
    localparam int WPORT_STARVE = 8;

endpackage

// File: rtl/rf_wreq_fifo.sv
// Small synchronous FIFO of register-file write requests with per-entry
// destination compares, so ID can tell whether a register has a queued write.
module rf_wreq_fifo
    import mips_abb_pkg::*;
#(
    parameter int DEPTH = WPORT_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    input  logic          push,
    input  rf_wreq_t      push_req,
    input  logic          pop,
    output rf_wreq_t      head,
    output logic [CW-1:0] cnt,
    output logic          empty,
    output logic          full,
    input  reg_addr       chk_add1,
    input  reg_addr       chk_add2,
    input  reg_addr       chk_add3,
    output logic          match1,
    output logic          match2,
    output logic          match3
);

    rf_wreq_t         mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] live;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst_n == RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; only pointers and count are, which makes every entry dead.
    always_ff @(posedge cpu_clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        live   = '0;
        match1 = 1'b0;
        match2 = 1'b0;
        match3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // Entry i is live when its distance from the read pointer is below the count.
            live[i] = (CW'(PW'(i) - rd_ptr) < cnt);
            if (live[i] && mem[i].add == chk_add1) match1 = 1'b1;
            if (live[i] && mem[i].add == chk_add2) match2 = 1'b1;
            if (live[i] && mem[i].add == chk_add3) match3 = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register-file write port: WB always wins, long-latency results
// queue and drain on idle cycles, and a starvation timer requests a WB bubble.
module rf_wport_arbiter
    import mips_abb_pkg::*;
#(
    parameter int DEPTH      = WPORT_DEPTH,
    parameter int STARVE_MAX = WPORT_STARVE
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst_n,
    input  logic                   wb_en,
    input  reg_addr                wb_add,
    input  reg_word                wb_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  reg_addr                lu_add,
    input  reg_word                lu_data,
    output logic                   rf_write_en,
    output reg_addr                rf_write_add,
    output reg_word                rf_write_data,
    input  reg_addr                id_chk_add1,
    input  reg_addr                id_chk_add2,
    output logic                   id_busy1,
    output logic                   id_busy2,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int WW = $clog2(STARVE_MAX + 1);

    logic          run;
    logic          wb_sel;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    rf_wreq_t      head;
    logic          match1;
    logic          match2;
    logic          wb_hit;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_next;

    assign run      = (cpu_rst_n != RESET);
    assign wb_sel   = wb_en && (wb_add != REG_ZERO);
    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign lu_ready = run && !full;
    assign push     = lu_valid && lu_ready && (lu_add != REG_ZERO);
    assign pop      = run && !wb_sel && !empty;

    rf_wreq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .cpu_clk  (cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .push     (push),
        .push_req ('{add: lu_add, data: lu_data}),
        .pop      (pop),
        .head     (head),
        .cnt      (fifo_cnt),
        .empty    (empty),
        .full     (full),
        .chk_add1 (id_chk_add1),
        .chk_add2 (id_chk_add2),
        .chk_add3 (wb_add),
        .match1   (match1),
        .match2   (match2),
        .match3   (wb_hit)
    );

    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_add  = REG_ZERO;
        rf_write_data = '0;
        if (run && wb_sel) begin
            rf_write_en   = 1'b1;
            rf_write_add  = wb_add;
            rf_write_data = wb_data;
        end else if (pop) begin
            rf_write_en   = 1'b1;
            rf_write_add  = head.add;
            rf_write_data = head.data;
        end
    end

    // The head being popped still counts as busy; ID sees its value via the regfile bypass.
    assign id_busy1 = run && (id_chk_add1 != REG_ZERO) && match1;
    assign id_busy2 = run && (id_chk_add2 != REG_ZERO) && match2;

    always_comb begin
        wait_next = wait_cnt;
        if (empty || pop)
            wait_next = '0;
        else if (wait_cnt < WW'(STARVE_MAX))
            wait_next = wait_cnt + WW'(1);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst_n == RESET) begin
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            wait_cnt  <= wait_next;
            stall_req <= (wait_next >= WW'(STARVE_MAX));
        end
    end

    // ID must interlock on busy, so WB may never target a register that is still queued.
    always_ff @(posedge cpu_clk) begin
        if (run && wb_sel)
            assert (!wb_hit)
            else $error("rf_wport_arbiter: WB writes r%0d while a queued write targets it", wb_add);
    end

endmodule
